// File: rtl/spi_peripheral.sv
// SPI mode-0 write peripheral holding the five 8-bit PWM control registers (0x00..0x04).
// Latency: register updates SYNC_STAGES+2 clk edges after the first edge that samples ncs high.
// No backpressure: SPI is controller-paced; invalid or incomplete frames are silently dropped.
// Optional build macro SPI_READBACK_EN adds read frames (bit 15 = 0) returned on cipo.
module spi_peripheral #(
    parameter int SYNC_STAGES = 2,
    parameter int MAX_ADDR    = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic       cipo,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SHIFT  = 2'd1;
    localparam logic [1:0] ST_COMMIT = 2'd2;

    // Edges are masked until the synchronisers have flushed their reset
    // values, so a pin held low through reset never fakes an ncs fall.
    localparam int                 FLUSH_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [FLUSH_W-1:0] FLUSH_DONE = FLUSH_W'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_copi_sync;
    logic [SYNC_STAGES-1:0] r_ncs_sync;
    logic                   r_sclk_d;
    logic                   r_ncs_d;
    logic [FLUSH_W-1:0]     r_flush;

    logic [1:0]  r_state;
    logic [4:0]  r_cnt;
    logic [15:0] r_sr;

    logic        r_wr_vld;
    logic [6:0]  r_wr_addr;
    logic [7:0]  r_wr_dat;

    logic [7:0]  r_reg0;
    logic [7:0]  r_reg1;
    logic [7:0]  r_reg2;
    logic [7:0]  r_reg3;
    logic [7:0]  r_reg4;

    logic w_sclk_s;
    logic w_copi_s;
    logic w_ncs_s;
    logic w_armed;
    logic w_sclk_rise;
    logic w_ncs_rise;
    logic w_ncs_fall;
    logic w_frame_ok;

    assign w_sclk_s    = r_sclk_sync[SYNC_STAGES-1];
    assign w_copi_s    = r_copi_sync[SYNC_STAGES-1];
    assign w_ncs_s     = r_ncs_sync[SYNC_STAGES-1];
    assign w_armed     = (r_flush == FLUSH_DONE);
    assign w_sclk_rise = w_armed & w_sclk_s & ~r_sclk_d;
    assign w_ncs_rise  = w_armed & w_ncs_s & ~r_ncs_d;
    assign w_ncs_fall  = w_armed & ~w_ncs_s & r_ncs_d;

    // Only a full 16-bit write to an in-range address is committed.
    assign w_frame_ok  = (r_cnt == 5'd16) && r_sr[15] && (r_sr[14:8] <= 7'(MAX_ADDR));

    // Input synchronisers plus one extra stage for edge detection; reset to idle pin levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= '0;
            r_copi_sync <= '0;
            r_ncs_sync  <= '1;
            r_sclk_d    <= 1'b0;
            r_ncs_d     <= 1'b1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
            r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi};
            r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], ncs};
            r_sclk_d    <= w_sclk_s;
            r_ncs_d     <= w_ncs_s;
        end
    end

    // Post-reset flush counter that arms edge detection once the chains hold real pin levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_flush <= '0;
        end else if (r_flush != FLUSH_DONE) begin
            r_flush <= r_flush + 1'b1;
        end
    end

    // Frame FSM: collect bits while selected, judge the frame for one cycle after deselect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= 5'd0;
            r_sr    <= 16'h0000;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= 5'd0;
                    if (w_ncs_fall) begin
                        r_state <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (w_ncs_rise) begin
                        r_state <= ST_COMMIT;
                    end else if (w_sclk_rise) begin
                        r_sr <= {r_sr[14:0], w_copi_s};
                        if (r_cnt != 5'd17) begin
                            r_cnt <= r_cnt + 5'd1;
                        end
                    end
                end
                ST_COMMIT: begin
                    r_cnt   <= 5'd0;
                    r_state <= w_ncs_fall ? ST_SHIFT : ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 5'd0;
                end
            endcase
        end
    end

    // Write stage: latch the judged frame so the register file sees one clean write strobe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_vld  <= 1'b0;
            r_wr_addr <= 7'd0;
            r_wr_dat  <= 8'h00;
        end else begin
            r_wr_vld  <= (r_state == ST_COMMIT) && w_frame_ok;
            r_wr_addr <= r_sr[14:8];
            r_wr_dat  <= r_sr[7:0];
        end
    end

    // Control register file; values change only on a committed write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_reg0 <= 8'h00;
            r_reg1 <= 8'h00;
            r_reg2 <= 8'h00;
            r_reg3 <= 8'h00;
            r_reg4 <= 8'h00;
        end else if (r_wr_vld) begin
            case (r_wr_addr)
                7'd0:    r_reg0 <= r_wr_dat;
                7'd1:    r_reg1 <= r_wr_dat;
                7'd2:    r_reg2 <= r_wr_dat;
                7'd3:    r_reg3 <= r_wr_dat;
                7'd4:    r_reg4 <= r_wr_dat;
                default: ;
            endcase
        end
    end

    assign en_reg_out_7_0  = r_reg0;
    assign en_reg_out_15_8 = r_reg1;
    assign en_reg_pwm_7_0  = r_reg2;
    assign en_reg_pwm_15_8 = r_reg3;
    assign pwm_duty_cycle  = r_reg4;

`ifdef SPI_READBACK_EN
    logic [7:0] r_rb;
    logic [6:0] w_rd_addr;
    logic [7:0] w_rd_dat;
    logic       w_sclk_fall;

    assign w_sclk_fall = w_armed & ~w_sclk_s & r_sclk_d;
    // Address as it will stand once the 8th bit is shifted in.
    assign w_rd_addr   = {r_sr[5:0], w_copi_s};

    // Read mux; unmapped or out-of-range addresses return zero.
    always_comb begin
        w_rd_dat = 8'h00;
        if (w_rd_addr <= 7'(MAX_ADDR)) begin
            case (w_rd_addr)
                7'd0:    w_rd_dat = r_reg0;
                7'd1:    w_rd_dat = r_reg1;
                7'd2:    w_rd_dat = r_reg2;
                7'd3:    w_rd_dat = r_reg3;
                7'd4:    w_rd_dat = r_reg4;
                default: w_rd_dat = 8'h00;
            endcase
        end
    end

    // Output shifter: load on the 8th rise of a read, advance on falls after the 9th rise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rb <= 8'h00;
        end else if (w_ncs_rise) begin
            r_rb <= 8'h00;
        end else if (r_state == ST_SHIFT) begin
            if (w_sclk_rise && (r_cnt == 5'd7) && !r_sr[6]) begin
                r_rb <= w_rd_dat;
            end else if (w_sclk_fall && (r_cnt >= 5'd9)) begin
                r_rb <= {r_rb[6:0], 1'b0};
            end
        end
    end

    assign cipo = r_rb[7];
`else
    assign cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_peripheral.sv
// Directed bench for spi_peripheral: register writes, invalid frames, mid-frame reset, readback.
// Expected register snapshots and cipo bits are queued when a frame is driven, popped when checked.
// Build with or without SPI_READBACK_EN; the expected cipo stream follows the same macro.
module tb_spi_peripheral;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       sclk  = 1'b0;
    logic       copi  = 1'b0;
    logic       ncs   = 1'b1;
    logic       cipo;
    logic [7:0] reg0, reg1, reg2, reg3, reg4;

    int n_chk  = 0;
    int n_fail = 0;

    logic [7:0]  mdl [5];
    logic [39:0] snap_q [$];
    logic        cipo_q [$];

    spi_peripheral #(.SYNC_STAGES(2), .MAX_ADDR(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .sclk            (sclk),
        .copi            (copi),
        .ncs             (ncs),
        .cipo            (cipo),
        .en_reg_out_7_0  (reg0),
        .en_reg_out_15_8 (reg1),
        .en_reg_pwm_7_0  (reg2),
        .en_reg_pwm_15_8 (reg3),
        .pwm_duty_cycle  (reg4)
    );

    always #5 clk = ~clk;

    function automatic logic [39:0] model_snap();
        return {mdl[4], mdl[3], mdl[2], mdl[1], mdl[0]};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_regs(input string tag, input logic [39:0] exp);
        logic [39:0] obs;
        obs = {reg4, reg3, reg2, reg1, reg0};
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: regs observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_cipo(input string tag, input logic exp);
        n_chk++;
        assert (cipo === exp) else begin
            n_fail++;
            $error("FAIL %s: cipo observed %b expected %b", tag, cipo, exp);
        end
    endtask

    // Drives one frame of n bits (MSB first), then checks exact write latency.
    task automatic frame(input string tag, input logic [31:0] w, input int n, input bit chk_rd);
        logic [39:0] prior;
        logic [7:0]  rb;
        prior = model_snap();
        rb = 8'h00;
`ifdef SPI_READBACK_EN
        if (n == 16 && !w[15] && w[14:8] <= 7'd4) rb = mdl[w[10:8]];
`endif
        if (n == 16 && w[15] && w[14:8] <= 7'd4) mdl[w[10:8]] = w[7:0];
        snap_q.push_back(model_snap());
        if (chk_rd) for (int k = 7; k >= 0; k--) cipo_q.push_back(rb[k]);

        ncs = 1'b0;
        cyc(4);
        for (int i = n - 1; i >= 0; i--) begin
            copi = w[i];
            cyc(4);
            if (chk_rd && i <= 7) chk_cipo({tag, "_cipo"}, cipo_q.pop_front());
            sclk = 1'b1;
            cyc(4);
            sclk = 1'b0;
        end
        cyc(4);
        copi = 1'b0;
        ncs  = 1'b1;
        cyc(4);
        chk_regs({tag, "_early"}, prior);
        cyc(1);
        chk_regs(tag, snap_q.pop_front());
        if (chk_rd) chk_cipo({tag, "_cipo_idle"}, 1'b0);
    endtask

    initial begin
        logic [31:0] w;
        for (int i = 0; i < 5; i++) mdl[i] = 8'h00;

        cyc(3);
        chk_regs("reset_regs", 40'h0);
        chk_cipo("reset_cipo", 1'b0);
        rst_n = 1'b1;
        cyc(8);

        frame("w80F0", 32'h80F0, 16, 1'b0);
        frame("w8480", 32'h8480, 16, 1'b0);
        frame("w8500_addr5", 32'h8500, 16, 1'b0);
        frame("w8111", 32'h8111, 16, 1'b0);
        frame("bits15", 32'h0122, 15, 1'b0);
        frame("bits17", 32'h181CD, 17, 1'b0);
        frame("rd_as_write", 32'h0155, 16, 1'b0);

        // Reset in the middle of a write: registers clear at once, partial frame is lost.
        w = 32'h82AA;
        ncs = 1'b0;
        cyc(4);
        for (int i = 15; i >= 7; i--) begin
            copi = w[i];
            cyc(4);
            sclk = 1'b1;
            cyc(4);
            sclk = 1'b0;
        end
        rst_n = 1'b0;
        for (int i = 0; i < 5; i++) mdl[i] = 8'h00;
        #1;
        chk_regs("rst_async", model_snap());
        cyc(3);
        rst_n = 1'b1;
        cyc(6);
        copi = 1'b0;
        ncs  = 1'b1;
        cyc(5);
        chk_regs("rst_partial_dropped", model_snap());
        cyc(4);

        frame("w8255", 32'h8255, 16, 1'b0);
        frame("w8301", 32'h8301, 16, 1'b0);
        frame("w8302", 32'h8302, 16, 1'b0);

        frame("w84C3", 32'h84C3, 16, 1'b1);
        frame("r0400", 32'h0400, 16, 1'b1);
        frame("r0200", 32'h0200, 16, 1'b1);
        frame("r0700_oor", 32'h0700, 16, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_peripheral.md
# spi_peripheral

SPI mode-0 peripheral that receives 16-bit write transactions from the off-chip controller and maintains the five 8-bit control registers consumed by the PWM output stage. It sits directly upstream of the PWM generator. All SPI pins are asynchronous to `clk` and are synchronised internally. Register outputs change only on a validated, complete transaction.

## Interface
- `SYNC_STAGES`, 2: flip-flop depth of each input synchroniser (`sclk`, `copi`, `ncs`); minimum 2.
- `MAX_ADDR`, 4: highest writable register address; higher addresses are ignored.
- `clk`  in  1  system clock; single clock domain.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `sclk`  in  1  SPI clock (mode 0: idle low, sample on rising edge), asynchronous.
- `copi`  in  1  controller-out data, MSB first, asynchronous.
- `ncs`  in  1  chip select, active-low, asynchronous.
- `cipo`  out  1  controller-in data; see Configuration.
- `en_reg_out_7_0`  out  8  register 0x00: output enables for `uo_out[7:0]`.
- `en_reg_out_15_8`  out  8  register 0x01: output enables for `uio_out[7:0]`.
- `en_reg_pwm_7_0`  out  8  register 0x02: PWM select for `uo_out[7:0]`.
- `en_reg_pwm_15_8`  out  8  register 0x03: PWM select for `uio_out[7:0]`.
- `pwm_duty_cycle`  out  8  register 0x04: duty cycle, 0x00 = 0 %, 0xFF = 100 %.

## Operation
- Frame: 16 bits, MSB first. Bit 15 = R/W (1 = write), bits 14:8 = address, bits 7:0 = data.
- Synchronisers: `SYNC_STAGES` FFs per input. Edge detection compares the last synchroniser stage against one extra registered copy.
- FSM states:
  - IDLE: bit counter = 0. On the synced `ncs` falling edge -> SHIFT.
  - SHIFT: on each synced `sclk` rising edge, shift synced `copi` into a 16-bit shift register. The 5-bit bit counter saturates at 17.
  - SHIFT exit: on the synced `ncs` rising edge -> COMMIT.
  - COMMIT: lasts one cycle, then -> IDLE.
- Validity: a transaction is committed only if counter == 16, bit 15 = 1, and address <= `MAX_ADDR`. Otherwise it is discarded silently and no register changes.
- `sclk` edges while `ncs` is high are ignored; the counter is not advanced.
- An `ncs` rising edge in IDLE (no preceding fall seen) is ignored.
- An `ncs` falling edge in the same cycle as a COMMIT is accepted; the FSM enters SHIFT on the next cycle with the counter cleared.
- Reset values:
  - All five registers = 0x00.
  - `cipo` = 0; FSM = IDLE; counter = 0; shift register = 0.
  - Synchroniser FFs reset to the idle pin levels: `ncs` = 1, `sclk` = 0, `copi` = 0.
- Reset asserted mid-transaction: the transaction is lost, registers go to 0x00 immediately (asynchronously). After release, bits of the partial frame are not committed. The FSM waits for a fresh `ncs` falling edge.

## Timing
- `sclk` high and low phases must each be at least `SYNC_STAGES`+1 `clk` periods. `ncs` must be held high at least `SYNC_STAGES`+2 periods between frames.
- `copi` must be stable from `SYNC_STAGES` cycles before each `sclk` rise until `SYNC_STAGES` cycles after it.
- Write latency: the target register updates on the `clk` edge `SYNC_STAGES`+2 cycles after the first edge that samples `ncs` = 1. That is 4 cycles at default.
- Registers hold their value between commits. No glitch or partial value is ever visible downstream.

## Configuration
- `SPI_READBACK_EN` defined:
  - A frame with bit 15 = 0 is a read.
  - After the 8th rising `sclk` (address complete), register[address] is loaded into an 8-bit output shifter. Out-of-range addresses load 0x00.
  - `cipo` presents the MSB within `SYNC_STAGES`+1 cycles of the 8th synced `sclk` rise. It advances one bit on each synced `sclk` falling edge for bits 7..0.
  - `cipo` returns to 0 when `ncs` (synced) goes high.
  - Reads never modify registers.
- `SPI_READBACK_EN` undefined:
  - `cipo` is tied to 0 and the output shifter is not built.
  - Read frames are discarded like any other invalid frame.

## Test plan
- Reset, then write 0x80F0 (write, addr 0x00, data 0xF0) -> `en_reg_out_7_0` = 0xF0 exactly 4 cycles after `ncs` rise; all other registers stay 0x00.
- Write 0x84 0x80 -> `pwm_duty_cycle` = 0x80. Write 0x8500 (addr 5) -> no register changes.
- 15-bit frame 0x81xx, and a 17-bit frame -> both discarded; `en_reg_out_15_8` unchanged.
- Assert `rst_n` low after 9 bits of write 0x82AA, release it, then raise `ncs` -> `en_reg_pwm_7_0` = 0x00. The next full write 0x8255 -> 0x55.
- Back-to-back writes 0x8301 then 0x8302 with minimum `ncs` high time -> `en_reg_pwm_15_8` = 0x01, then 0x02.
- With `SPI_READBACK_EN`: write 0x84C3, then read 0x0400 -> `cipo` shifts out 1,1,0,0,0,0,1,1 on bits 7..0; `pwm_duty_cycle` stays 0xC3. Without the macro: `cipo` = 0 throughout.
